// File: rtl/vx_burst_rr_arbiter_pkg.sv
// ============================================================================
// Module      : vx_arb_pkg
// Description : Shared types and helpers for the burst round-robin arbiter:
//               FSM state encoding, index-width helper and the rotating
//               priority mask used by the double-width pick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vx_arb_pkg;

  // Arbiter FSM: free to arbitrate, or holding a grant for a burst
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Widest requester vector the priority-mask helper can describe
  localparam int unsigned c_MAX_REQS = 64;

  // Index width that never collapses to zero bits
  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits strictly above the last winner and below the requester count.
  // These requesters outrank everyone at or below the pointer this round.
  function automatic logic [c_MAX_REQS-1:0] rr_mask(input int unsigned ptr,
                                                    input int unsigned n);
    logic [c_MAX_REQS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < c_MAX_REQS; i++) begin
      if ((i > ptr) && (i < n)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/VX_onehot_encoder.sv
// ============================================================================
// Module      : VX_onehot_encoder
// Description : Library one-hot to binary encoder. OR-reduces the indices of
//               all set bits, so a true one-hot input yields its position;
//               REVERSE mirrors the index numbering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module VX_onehot_encoder
  import vx_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int REVERSE = 0,
  parameter int LN      = log2up(N)
) (
  input  logic [N-1:0]  data_in,
  output logic [LN-1:0] data_out,
  output logic          valid_out
);

  // Encode by OR-ing together the index of every set input bit
  always_comb begin
    data_out = '0;
    for (int i = 0; i < N; i++) begin
      if (data_in[i]) begin
        data_out = data_out | LN'((REVERSE != 0) ? (N - 1 - i) : i);
      end
    end
  end

  // Flag that some input bit is set
  always_comb begin
    valid_out = |data_in;
  end

endmodule

`default_nettype wire

// File: rtl/vx_burst_rr_arbiter.sv
// ============================================================================
// Module      : vx_burst_rr_arbiter
// Description : Round-robin arbiter for one shared downstream port with
//               optional burst locking. The winner keeps the grant until it
//               flags end-of-burst or the burst-length cap is reached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_burst_rr_arbiter
  import vx_arb_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int LOCK_ENABLE  = 1,
  parameter int MAX_BURST    = 8,
  parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQS-1:0]     req_valid,
  input  logic [NUM_REQS-1:0]     req_last,
  output logic [NUM_REQS-1:0]     grant_onehot,
  output logic [LOG_NUM_REQS-1:0] grant_index,
  output logic                    grant_valid,
  input  logic                    grant_ready
);

  // NUM_REQS must not exceed c_MAX_REQS (width of the rotating-mask helper)
  localparam int                      c_CNT_W    = log2up(MAX_BURST);
  localparam bit                      c_CAN_LOCK = (LOCK_ENABLE != 0) && (MAX_BURST > 1);
  localparam logic [c_CNT_W-1:0]      c_CNT_LAST = c_CNT_W'(MAX_BURST - 1);
  localparam logic [c_CNT_W-1:0]      c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [LOG_NUM_REQS-1:0] c_PTR_RST  = LOG_NUM_REQS'(NUM_REQS - 1);

  arb_state_e                state_q,     state_d;
  logic [LOG_NUM_REQS-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [LOG_NUM_REQS-1:0]   lock_idx_q,  lock_idx_d;
  logic [c_CNT_W-1:0]        burst_cnt_q, burst_cnt_d;

  logic [c_MAX_REQS-1:0]     w_mask_full;
  logic [NUM_REQS-1:0]       w_mask;
  logic [2*NUM_REQS-1:0]     w_dbl;
  logic [2*NUM_REQS-1:0]     w_dbl_oh;
  logic                      w_found;
  logic [NUM_REQS-1:0]       w_rr_oh;
  logic [NUM_REQS-1:0]       w_lock_oh;
  logic                      w_fire;
  logic                      w_last_hit;
  logic                      w_enc_valid_unused;

  // Rotating priority: lower half holds requesters above the last winner,
  // upper half holds everyone, so the first set bit wraps without modulo
  always_comb begin
    w_mask_full = rr_mask(32'(rr_ptr_q), NUM_REQS);
    w_mask      = w_mask_full[NUM_REQS-1:0];
    w_dbl       = {req_valid, req_valid & w_mask};
  end

  // Lowest set bit of the double-width vector, folded back to NUM_REQS bits
  always_comb begin
    w_dbl_oh = '0;
    w_found  = 1'b0;
    for (int i = 0; i < 2 * NUM_REQS; i++) begin
      if (w_dbl[i] && !w_found) begin
        w_dbl_oh[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
    w_rr_oh = w_dbl_oh[NUM_REQS-1:0] | w_dbl_oh[2*NUM_REQS-1:NUM_REQS];
  end

  // Decode the locked requester into a one-hot vector
  always_comb begin
    w_lock_oh = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_lock_oh[i] = (lock_idx_q == LOG_NUM_REQS'(i));
    end
  end

  // Grant outputs: fresh pick when idle, pinned to the owner when locked
  always_comb begin
    if (state_q == LOCKED) begin
      grant_onehot = w_lock_oh;
      grant_valid  = |(req_valid & w_lock_oh);
    end else begin
      grant_onehot = w_rr_oh;
      grant_valid  = |req_valid;
    end
  end

  VX_onehot_encoder #(
    .N       (NUM_REQS),
    .REVERSE (0),
    .LN      (LOG_NUM_REQS)
  ) u_grant_enc (
    .data_in   (grant_onehot),
    .data_out  (grant_index),
    .valid_out (w_enc_valid_unused)
  );

  // Transfer handshake and the current grantee's end-of-burst flag
  always_comb begin
    w_fire     = grant_valid & grant_ready;
    w_last_hit = |(req_last & grant_onehot);
  end

  // Next-state: registers move only on a transfer, otherwise they hold
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    burst_cnt_d = burst_cnt_q;
    if (w_fire) begin
      case (state_q)
        IDLE: begin
          rr_ptr_d = grant_index;
          if (c_CAN_LOCK && !w_last_hit) begin
            state_d     = LOCKED;
            lock_idx_d  = grant_index;
            burst_cnt_d = c_CNT_ONE;
          end
        end
        LOCKED: begin
          // rr_ptr already equals lock_idx from the transfer that locked
          if (w_last_hit || (burst_cnt_q == c_CNT_LAST)) begin
            state_d = IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + c_CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; async reset drops any lock immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= c_PTR_RST;
      lock_idx_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vx_burst_rr_arbiter.sv
// ============================================================================
// Module      : tb_vx_burst_rr_arbiter
// Description : Self-checking bench for vx_burst_rr_arbiter. Three instances
//               (default, burst cap 4, three requesters) share clock and
//               reset; expected grant indices are queued as stimulus is set
//               up and popped whenever an instance completes a transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_burst_rr_arbiter;

  logic clk;
  logic reset_n;

  // Instance A: defaults (4 requesters, lock on, cap 8)
  logic [3:0] a_valid, a_last, a_oh;
  logic [1:0] a_idx;
  logic       a_gv, a_ready;

  // Instance B: 4 requesters, cap 4
  logic [3:0] b_valid, b_last, b_oh;
  logic [1:0] b_idx;
  logic       b_gv, b_ready;

  // Instance C: 3 requesters
  logic [2:0] c_valid, c_last, c_oh;
  logic [1:0] c_idx;
  logic       c_gv, c_ready;

  int exp_a[$];
  int exp_b[$];
  int exp_c[$];

  int n_checks;
  int n_pass;

  vx_burst_rr_arbiter u_dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_last(a_last),
    .grant_onehot(a_oh), .grant_index(a_idx), .grant_valid(a_gv), .grant_ready(a_ready)
  );

  vx_burst_rr_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(1), .MAX_BURST(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_last(b_last),
    .grant_onehot(b_oh), .grant_index(b_idx), .grant_valid(b_gv), .grant_ready(b_ready)
  );

  vx_burst_rr_arbiter #(.NUM_REQS(3)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .req_valid(c_valid), .req_last(c_last),
    .grant_onehot(c_oh), .grant_index(c_idx), .grant_valid(c_gv), .grant_ready(c_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Sample on the falling edge; every transfer must match the queue head
  task automatic at_sample();
    int e;
    @(negedge clk);
    if (a_gv && a_ready) begin
      if (exp_a.size() == 0) chk("a_spurious_fire_qsize", 32'(exp_a.size()), 32'd1);
      else begin
        e = exp_a.pop_front();
        chk("a_grant_index", 32'(a_idx), 32'(e));
        chk("a_grant_onehot", 32'(a_oh), 32'(1 << e));
      end
    end
    if (b_gv && b_ready) begin
      if (exp_b.size() == 0) chk("b_spurious_fire_qsize", 32'(exp_b.size()), 32'd1);
      else begin
        e = exp_b.pop_front();
        chk("b_grant_index", 32'(b_idx), 32'(e));
        chk("b_grant_onehot", 32'(b_oh), 32'(1 << e));
      end
    end
    if (c_gv && c_ready) begin
      if (exp_c.size() == 0) chk("c_spurious_fire_qsize", 32'(exp_c.size()), 32'd1);
      else begin
        e = exp_c.pop_front();
        chk("c_grant_index", 32'(c_idx), 32'(e));
        chk("c_grant_onehot", 32'(c_oh), 32'(1 << e));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    at_sample();
    advance();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    a_valid = '0; a_last = '0; a_ready = 1'b0;
    b_valid = '0; b_last = '0; b_ready = 1'b0;
    c_valid = '0; c_last = '0; c_ready = 1'b0;

    // Reset state: idle function with requester 0 first in line
    #2;
    chk("rst_a_valid_none", 32'(a_gv), 32'd0);
    chk("rst_a_onehot_none", 32'(a_oh), 32'd0);
    a_valid = 4'b0110;
    c_valid = 3'b110;
    #1;
    chk("rst_a_onehot_pick", 32'(a_oh), 32'h2);
    chk("rst_a_index_pick", 32'(a_idx), 32'd1);
    chk("rst_a_valid_pick", 32'(a_gv), 32'd1);
    chk("rst_c_onehot_pick", 32'(c_oh), 32'h2);
    a_valid = '0;
    c_valid = '0;
    advance();
    reset_n = 1'b1;

    // Basic rotation on A
    a_valid = 4'hF; a_last = 4'hF; a_ready = 1'b1;
    exp_a.push_back(0); exp_a.push_back(1); exp_a.push_back(2);
    exp_a.push_back(3); exp_a.push_back(0);
    repeat (5) cycle();
    a_valid = '0;

    // Burst lock: requester 2 sends 3 beats while 0 and 3 wait
    a_valid = 4'b1101; a_last = 4'b1001;
    exp_a.push_back(2); exp_a.push_back(2); exp_a.push_back(2);
    exp_a.push_back(3); exp_a.push_back(0);
    cycle();
    cycle();
    a_last = 4'b1101;
    cycle();
    a_valid = 4'b1001; a_last = 4'b1001;
    cycle();
    a_valid = 4'b0001;
    cycle();
    a_valid = '0;

    // Lock held while the owner idles; other requesters stay blocked
    a_valid = 4'b0010; a_last = 4'b0000;
    exp_a.push_back(1);
    cycle();
    a_valid = 4'b1000; a_last = 4'b1000;
    repeat (3) begin
      at_sample();
      chk("a_hold_onehot", 32'(a_oh), 32'h2);
      chk("a_hold_valid", 32'(a_gv), 32'd0);
      advance();
    end
    a_valid = 4'b1010; a_last = 4'b1010;
    exp_a.push_back(1);
    cycle();
    a_valid = 4'b1000;
    exp_a.push_back(3);
    cycle();
    a_valid = '0;

    // Burst cap and backpressure on B: requester 1 never ends its burst
    b_valid = 4'b0110; b_last = 4'b0100; b_ready = 1'b1;
    exp_b.push_back(1); exp_b.push_back(1);
    cycle();
    cycle();
    b_ready = 1'b0;
    repeat (5) begin
      at_sample();
      chk("b_bp_onehot", 32'(b_oh), 32'h2);
      chk("b_bp_valid", 32'(b_gv), 32'd1);
      advance();
    end
    b_ready = 1'b1;
    exp_b.push_back(1); exp_b.push_back(1); exp_b.push_back(2);
    cycle();
    cycle();
    cycle();
    b_valid = 4'b0010;
    exp_b.push_back(1);
    cycle();
    b_valid = '0;

    // Non-power-of-two wrap on C
    c_valid = 3'b101; c_last = 3'b111; c_ready = 1'b1;
    exp_c.push_back(0); exp_c.push_back(2); exp_c.push_back(0); exp_c.push_back(2);
    repeat (4) cycle();
    c_valid = 3'b100;
    exp_c.push_back(2);
    cycle();
    c_valid = '0;

    // Async reset mid-burst: lock A on requester 3 then pulse reset
    a_valid = 4'b1000; a_last = 4'b0000; a_ready = 1'b1;
    exp_a.push_back(3);
    cycle();
    a_valid = 4'b1001; a_last = 4'b0001; a_ready = 1'b0;
    at_sample();
    chk("a_locked3_onehot", 32'(a_oh), 32'h8);
    chk("a_locked3_valid", 32'(a_gv), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("a_arst_onehot", 32'(a_oh), 32'h1);
    chk("a_arst_index", 32'(a_idx), 32'd0);
    chk("a_arst_valid", 32'(a_gv), 32'd1);
    #1 reset_n = 1'b1;
    advance();
    a_ready = 1'b1; a_last = 4'b1001;
    exp_a.push_back(0);
    cycle();
    a_valid = 4'b1000;
    exp_a.push_back(3);
    cycle();
    a_valid = '0;
    repeat (2) cycle();

    // Every queued grant must have been seen
    chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    chk("c_queue_drained", 32'(exp_c.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
